// File: rtl/pipe_pkg.sv
// Shared pipeline types and defaults for the fetch stage.
package pipe_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 8;

  localparam logic [PC_W-1:0]    RESET_PC  = '0;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, ir} entries with push/pop/flush and an occupancy count.
module fetch_fifo
  import pipe_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head = (count == '0) ? fetch_entry_t'{pc: '0, ir: NOP_INSTR} : mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, in-flight tracking and FIFO credit logic.
// Optional performance counters are built when IFU_PERF_CNT_EN is defined.
module instr_fetch_unit
  import pipe_pkg::*;
#(
  parameter  int                INSTR_W  = pipe_pkg::INSTR_W,
  parameter  int                PC_W     = pipe_pkg::PC_W,
  parameter  int                DEPTH    = 4,
  parameter  logic [PC_W-1:0]   RESET_PC = pipe_pkg::RESET_PC,
  localparam int                CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               ifid_valid,
  input  logic               ifid_ready,
  output logic [INSTR_W-1:0] ifid_ir,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [CNT_W-1:0]   fifo_count
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_flushed
`endif
);

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] inflight_pc;
  logic            inflight;
  logic [CNT_W:0]  credit_used;
  logic            push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Pops are not credited, so a push can never find the FIFO full.
  assign credit_used = {1'b0, fifo_count} + (CNT_W + 1)'(inflight);
  assign imem_req    = reset && !redirect_valid && (credit_used < (CNT_W + 1)'(DEPTH));
  assign imem_addr   = fetch_pc;

  assign push       = inflight && !redirect_valid;
  assign ifid_valid = (fifo_count != '0) && !redirect_valid;
  assign pop        = ifid_valid && ifid_ready;
  assign push_entry = '{pc: inflight_pc, ir: imem_rdata};
  assign ifid_ir    = head.ir;
  assign ifid_pc    = head.pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc    <= fetch_pc + PC_W'(1);
        inflight_pc <= fetch_pc;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .count      (fifo_count)
  );

`ifdef IFU_PERF_CNT_EN
  logic [16:0] flushed_sum;

  // A redirect discards both buffered entries and the pending response.
  assign flushed_sum = {1'b0, perf_flushed} + 17'(credit_used);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop && (perf_fetched != 16'hFFFF)) perf_fetched <= perf_fetched + 16'd1;
      if (redirect_valid) perf_flushed <= flushed_sum[16] ? 16'hFFFF : flushed_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit against a queue-based reference model.
// Memory model: mem[a] = a + 0x100, returned one cycle after the request.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        ifid_valid;
  logic        ifid_ready = 1'b0;
  logic [15:0] ifid_ir;
  logic [7:0]  ifid_pc;
  logic [2:0]  fifo_count;
`ifdef IFU_PERF_CNT_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_flushed;
`endif

  always #5 clk = ~clk;

  logic [7:0] last_addr = '0;
  always @(posedge clk) last_addr <= imem_addr;
  assign imem_rdata = {8'h00, last_addr} + 16'h0100;

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_ready     (ifid_ready),
    .ifid_ir        (ifid_ir),
    .ifid_pc        (ifid_pc),
    .fifo_count     (fifo_count)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] ir;
  } ent_t;

  ent_t        q[$];
  logic [7:0]  m_pc = '0;
  logic [7:0]  m_ipc = '0;
  bit          m_inf = 1'b0;
  logic [15:0] m_fetched = '0;
  logic [15:0] m_flushed = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [15:0] satAdd(input logic [15:0] a, input int b);
    int s;
    s = int'(a) + b;
    return (s > 65535) ? 16'hFFFF : 16'(s);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    m_inf     = 1'b0;
    m_pc      = 8'h00;
    m_fetched = '0;
    m_flushed = '0;
  endtask

  // One clock cycle: drive inputs, check combinational outputs, advance the model at the edge.
  task automatic applyStimulus(input logic redir, input logic [7:0] rpc, input logic rdy);
    bit   exp_req;
    bit   exp_valid;
    int   occ;
    ent_t pushed;
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = rpc;
    ifid_ready     = rdy;
    #1;
    occ       = q.size() + int'(m_inf);
    exp_req   = (occ < 4) && !redir;
    exp_valid = (q.size() != 0) && !redir;
    checkOutput("imem_req", imem_req, exp_req);
    checkOutput("imem_addr", imem_addr, m_pc);
    checkOutput("ifid_valid", ifid_valid, exp_valid);
    checkOutput("ifid_ir", ifid_ir, (q.size() != 0) ? q[0].ir : 16'h0);
    checkOutput("ifid_pc", ifid_pc, (q.size() != 0) ? q[0].pc : 8'h0);
    @(posedge clk);
    if (redir) begin
      m_flushed = satAdd(m_flushed, occ);
      q.delete();
      m_inf = 1'b0;
      m_pc  = rpc;
    end else begin
      if (exp_valid && rdy) begin
        void'(q.pop_front());
        m_fetched = satAdd(m_fetched, 1);
      end
      if (m_inf) begin
        pushed.pc = m_ipc;
        pushed.ir = {8'h00, m_ipc} + 16'h0100;
        q.push_back(pushed);
      end
      if (exp_req) begin
        m_ipc = m_pc;
        m_pc  = m_pc + 8'd1;
        m_inf = 1'b1;
      end else begin
        m_inf = 1'b0;
      end
    end
    #1;
    checkOutput("fifo_count", fifo_count, q.size());
`ifdef IFU_PERF_CNT_EN
    checkOutput("perf_fetched", perf_fetched, m_fetched);
    checkOutput("perf_flushed", perf_flushed, m_flushed);
`endif
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_imem_req", imem_req, 1'b0);
    checkOutput("rst_imem_addr", imem_addr, 8'h00);
    checkOutput("rst_ifid_valid", ifid_valid, 1'b0);
    checkOutput("rst_ifid_ir", ifid_ir, 16'h0);
    checkOutput("rst_ifid_pc", ifid_pc, 8'h0);
    checkOutput("rst_fifo_count", fifo_count, 3'd0);
`ifdef IFU_PERF_CNT_EN
    checkOutput("rst_perf_fetched", perf_fetched, 16'h0);
    checkOutput("rst_perf_flushed", perf_flushed, 16'h0);
`endif
  endtask

  // Hold ready low until the model holds the target occupancy; an expired bound is a failure.
  task automatic fillTo(input int target);
    int k = 0;
    while (q.size() != target && k < 20) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      k++;
    end
    checkOutput("fill_timeout", q.size(), target);
  endtask

  initial begin
    $display("[TB] start");
    modelReset();
    #1;
    checkResetOutputs();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // Streaming with decode always ready.
    repeat (12) applyStimulus(1'b0, 8'h00, 1'b1);

    // Backpressure, then drain.
    repeat (10) applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (8) applyStimulus(1'b0, 8'h00, 1'b1);

    // Redirect with three buffered entries and one response pending.
    fillTo(3);
    checkOutput("inflight_before_redirect", 32'(m_inf), 1);
    applyStimulus(1'b1, 8'h40, 1'b0);
    repeat (6) applyStimulus(1'b0, 8'h00, 1'b1);

    // Redirect coincident with ready while two entries are buffered.
    fillTo(2);
    applyStimulus(1'b1, 8'h80, 1'b1);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1);

    // Back-to-back redirects, last one wins; then PC wrap.
    applyStimulus(1'b1, 8'h10, 1'b1);
    applyStimulus(1'b1, 8'hFE, 1'b1);
    repeat (8) applyStimulus(1'b0, 8'h00, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 15) == 0, 8'($urandom), $urandom_range(0, 3) != 0);
    end

    // Asynchronous reset mid-stream with three entries buffered.
    applyStimulus(1'b1, 8'h20, 1'b1);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1);
    fillTo(3);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    modelReset();
    checkResetOutputs();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (8) applyStimulus(1'b0, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
